dft_sequencer: RTL and testbench
================================

DFT_SEQUENCER -- requirements
Module: dft_sequencer

Interface
REQ-001 Parameters SHALL be:
- BASE_ADDR, default 32'h0000_0000: accelerator base address.
- IN_WORDS, default 64: input words per job.
- OUT_WORDS, default 64: result words per job.
- DIN_OFS, default 32'h0: data-in register offset.
- CTRL_OFS, default 32'h4: control register offset.
- STAT_OFS, default 32'h8: status register offset.
- DOUT_OFS, default 32'hC: data-out register offset.
- POLL_LIMIT, default 1024: maximum status reads per job.
REQ-002 Ports SHALL be as follows; one clock; reset is synchronous and active-high.
- clk  in  1  clock.
- rst_sys  in  1  reset.
- job_start  in  1  one-cycle job request.
- job_busy  out  1  job in progress.
- job_done  out  1  one-cycle completion pulse.
- job_err  out  2  result code: 0 ok, 1 bus error, 2 poll timeout; valid with job_done.
- in_data  in  32  input stream data.
- in_valid  in  1  input stream valid.
- in_ready  out  1  input stream ready.
- out_data  out  32  result stream data.
- out_valid  out  1  result stream valid.
- out_ready  in  1  result stream ready.
- wbm_adr_o  out  32  Wishbone B3 address.
- wbm_dat_o  out  32  write data.
- wbm_sel_o  out  4  byte select, constant 4'hF.
- wbm_cyc_o  out  1  cycle.
- wbm_stb_o  out  1  strobe.
- wbm_we_o  out  1  write enable.
- wbm_cti_o  out  3  constant 3'b000.
- wbm_bte_o  out  2  constant 2'b00.
- wbm_ack_i  in  1  acknowledge.
- wbm_err_i  in  1  bus error.
- wbm_rty_i  in  1  retry; treated as err.
- wbm_dat_i  in  32  read data.

Function
REQ-003 FSM states SHALL be IDLE, LOAD, KICK, POLL, UNLOAD, EMIT, FIN.
REQ-004 In IDLE, job_start=1 SHALL clear the word and poll counters and enter LOAD; job_start SHALL be ignored in every other state.
REQ-005 job_busy SHALL be 1 in every state except IDLE.
REQ-006 Bus cycles SHALL be classic single transfers: cyc_o=stb_o=1 with adr/dat/we stable until ack, err or rty is sampled, then deasserted for at least one cycle.
REQ-007 LOAD, per word:
- in_ready=1 only while LOAD has no bus cycle pending.
- An in_valid&in_ready handshake SHALL capture in_data and issue a write to BASE_ADDR+DIN_OFS.
- On ack the word count SHALL increment; after IN_WORDS acks the FSM SHALL enter KICK.
REQ-008 KICK SHALL write 32'h1 to BASE_ADDR+CTRL_OFS; on ack the FSM SHALL enter POLL.
REQ-009 POLL SHALL read BASE_ADDR+STAT_OFS and increment the poll counter on each ack.
- Bit0=1 on ack: enter UNLOAD.
- Bit0=0 on ack: reissue the read.
- Poll counter reaching POLL_LIMIT with bit0=0: enter FIN with job_err=2.
REQ-010 UNLOAD SHALL read BASE_ADDR+DOUT_OFS; on ack it SHALL latch wbm_dat_i into out_data and enter EMIT.
REQ-011 EMIT SHALL hold out_valid=1 with out_data stable until out_ready=1.
- After the handshake, return to UNLOAD while fewer than OUT_WORDS words have been emitted; otherwise enter FIN with job_err=0.
REQ-012 err or rty on any bus cycle SHALL end the cycle immediately and enter FIN with job_err=1; no further bus cycles SHALL occur for that job.
REQ-013 If ack and err are sampled in the same cycle, err SHALL win.
REQ-014 FIN SHALL pulse job_done=1 for exactly one cycle and return to IDLE; job_err SHALL hold its value until the next job_start.
REQ-015 Back-to-back operation: job_start in the cycle after job_done SHALL be accepted.

Reset
REQ-016 With rst_sys=1 at a clock edge, the next state SHALL be:
- FSM in IDLE and all counters at 0.
- cyc_o, stb_o, we_o, in_ready, out_valid, job_busy and job_done at 0.
- job_err at 0; adr_o, dat_o and out_data at 0.
REQ-017 Reset mid-job SHALL drop cyc_o the next cycle without waiting for ack; a later stray ack SHALL be ignored in IDLE.

Verification
REQ-018 Nominal job, IN_WORDS=OUT_WORDS=4:
- Stimulus: inputs 1..4; slave acks after 1 cycle; status returns 0,0,1; results A..D.
- Required: 4 writes to 0x0, 1 write of 1 to 0x4, 3 reads of 0x8, 4 reads of 0xC; out stream A,B,C,D; job_done with job_err=0.
REQ-019 Backpressure: out_ready low 5 cycles on the second result -> out_data holds B, no read of 0xC is issued meanwhile, job completes normally.
REQ-020 Bus error: err on the third LOAD write -> cyc_o drops that cycle, job_done with job_err=1, no KICK write.
REQ-021 Timeout: POLL_LIMIT=8 and status always 0 -> exactly 8 status reads, then job_done with job_err=2.
REQ-022 Reset during POLL with cyc_o=1 -> cyc_o=0 next cycle; a new job_start then runs the full nominal job.
REQ-023 job_start during LOAD -> ignored; exactly one job_done is produced.

Source files
------------

// File: rtl/dft_sequencer.sv
// dft_sequencer: drives a memory-mapped DFT accelerator over a Wishbone B3
// classic master port. Each job streams IN_WORDS operands into the data-in
// register, kicks the engine, polls status bit0, then drains OUT_WORDS
// results to the output stream. Bus errors and poll timeouts abort the job.
module dft_sequencer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          IN_WORDS   = 64,
  parameter int          OUT_WORDS  = 64,
  parameter logic [31:0] DIN_OFS    = 32'h0,
  parameter logic [31:0] CTRL_OFS   = 32'h4,
  parameter logic [31:0] STAT_OFS   = 32'h8,
  parameter logic [31:0] DOUT_OFS   = 32'hC,
  parameter int          POLL_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst_sys,
  input  logic        job_start,
  output logic        job_busy,
  output logic        job_done,
  output logic [1:0]  job_err,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i,
  input  logic [31:0] wbm_dat_i
);

  localparam int MAX_WORDS = (IN_WORDS > OUT_WORDS) ? IN_WORDS : OUT_WORDS;
  localparam int CW        = $clog2(MAX_WORDS + 1);
  localparam int PW        = $clog2(POLL_LIMIT + 1);

  localparam logic [CW-1:0] IN_N   = CW'(IN_WORDS);
  localparam logic [CW-1:0] OUT_N  = CW'(OUT_WORDS);
  localparam logic [PW-1:0] POLL_N = PW'(POLL_LIMIT);

  localparam logic [31:0] A_DIN  = BASE_ADDR + DIN_OFS;
  localparam logic [31:0] A_CTRL = BASE_ADDR + CTRL_OFS;
  localparam logic [31:0] A_STAT = BASE_ADDR + STAT_OFS;
  localparam logic [31:0] A_DOUT = BASE_ADDR + DOUT_OFS;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_KICK   = 3'd2;
  localparam logic [2:0] S_POLL   = 3'd3;
  localparam logic [2:0] S_UNLOAD = 3'd4;
  localparam logic [2:0] S_EMIT   = 3'd5;
  localparam logic [2:0] S_FIN    = 3'd6;

  localparam logic [1:0] ERR_OK  = 2'd0;
  localparam logic [1:0] ERR_BUS = 2'd1;
  localparam logic [1:0] ERR_TMO = 2'd2;

  // Outstanding bus request; held stable for the whole classic cycle.
  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

  logic [2:0]    state;
  logic [CW-1:0] word_cnt;
  logic [PW-1:0] poll_cnt;
  logic          cyc;
  wb_req_t       req;
  logic [31:0]   out_data_r;
  logic          out_valid_r;
  logic [1:0]    err_r;

  logic          term, bus_fail, bus_ok, in_hs;
  logic [CW-1:0] word_nxt;
  logic [PW-1:0] poll_nxt;

  // Responses only count while a cycle is open, so stray acks are harmless.
  assign term     = cyc & (wbm_ack_i | wbm_err_i | wbm_rty_i);
  assign bus_fail = cyc & (wbm_err_i | wbm_rty_i);
  assign bus_ok   = term & ~bus_fail;
  assign word_nxt = word_cnt + CW'(1);
  assign poll_nxt = poll_cnt + PW'(1);

  assign in_ready = (state == S_LOAD) && !cyc;
  assign in_hs    = in_valid & in_ready;

  assign job_busy  = (state != S_IDLE);
  assign job_done  = (state == S_FIN);
  assign job_err   = err_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;

  assign wbm_adr_o = req.adr;
  assign wbm_dat_o = req.dat;
  assign wbm_we_o  = req.we;
  assign wbm_cyc_o = cyc;
  assign wbm_stb_o = cyc;
  assign wbm_sel_o = 4'hF;
  assign wbm_cti_o = 3'b000;
  assign wbm_bte_o = 2'b00;

  // Job sequencer and bus master; a cycle closes on any response and a new
  // one is only opened while cyc is low, giving the mandatory idle gap.
  always_ff @(posedge clk) begin
    if (rst_sys) begin
      state       <= S_IDLE;
      word_cnt    <= '0;
      poll_cnt    <= '0;
      cyc         <= 1'b0;
      req         <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      err_r       <= ERR_OK;
    end else begin
      if (term) cyc <= 1'b0;
      case (state)
        S_IDLE: begin
          if (job_start) begin
            word_cnt <= '0;
            poll_cnt <= '0;
            err_r    <= ERR_OK;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_hs) begin
            cyc <= 1'b1;
            req <= '{we: 1'b1, adr: A_DIN, dat: in_data};
          end
          if (bus_ok) begin
            if (word_nxt == IN_N) begin
              word_cnt <= '0;
              state    <= S_KICK;
            end else begin
              word_cnt <= word_nxt;
            end
          end
        end
        S_KICK: begin
          if (!cyc) begin
            cyc <= 1'b1;
            req <= '{we: 1'b1, adr: A_CTRL, dat: 32'h1};
          end else if (bus_ok) begin
            state <= S_POLL;
          end
        end
        S_POLL: begin
          if (!cyc) begin
            cyc <= 1'b1;
            req <= '{we: 1'b0, adr: A_STAT, dat: req.dat};
          end else if (bus_ok) begin
            poll_cnt <= poll_nxt;
            if (wbm_dat_i[0]) begin
              state <= S_UNLOAD;
            end else if (poll_nxt == POLL_N) begin
              err_r <= ERR_TMO;
              state <= S_FIN;
            end
          end
        end
        S_UNLOAD: begin
          if (!cyc) begin
            cyc <= 1'b1;
            req <= '{we: 1'b0, adr: A_DOUT, dat: req.dat};
          end else if (bus_ok) begin
            out_data_r  <= wbm_dat_i;
            out_valid_r <= 1'b1;
            state       <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            word_cnt    <= word_nxt;
            state       <= (word_nxt == OUT_N) ? S_FIN : S_UNLOAD;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      // Error/retry beats everything, including a simultaneous ack.
      if (bus_fail) begin
        err_r <= ERR_BUS;
        state <= S_FIN;
      end
    end
  end

endmodule

// File: tb/tb_dft_sequencer.sv
// tb_dft_sequencer: randomized jobs against a Wishbone slave model; the
// expected bus transaction list, result stream and error code are derived
// from the job description (operands, status pattern, injected fault).
module tb_dft_sequencer;
  localparam int NI = 4;
  localparam int NO = 4;
  localparam int PL = 8;
  localparam logic [31:0] A_DIN  = 32'h0;
  localparam logic [31:0] A_CTRL = 32'h4;
  localparam logic [31:0] A_STAT = 32'h8;
  localparam logic [31:0] A_DOUT = 32'hC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_sys, job_start, job_busy, job_done;
  logic [1:0]  job_err;
  logic [31:0] in_data, out_data;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic        wbm_ack_i, wbm_err_i, wbm_rty_i;

  dft_sequencer #(.IN_WORDS(NI), .OUT_WORDS(NO), .POLL_LIMIT(PL)) dut (
    .clk(clk), .rst_sys(rst_sys), .job_start(job_start), .job_busy(job_busy),
    .job_done(job_done), .job_err(job_err), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_cti_o(wbm_cti_o),
    .wbm_bte_o(wbm_bte_o), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .wbm_rty_i(wbm_rty_i), .wbm_dat_i(wbm_dat_i)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } tx_t;

  int checks = 0;
  int failures = 0;

  // job description
  logic [31:0] in_vals [NI];
  logic [31:0] results [NO];
  int stall_n [NO];
  int n_zero = 0, err_idx = -1, err_mode = 0, lat_max = 0;

  // observations
  tx_t         log_q [$];
  logic [31:0] out_q [$];
  int bp_bad = 0, stable_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wishbone slave: random wait states, status/result sequences, fault injection.
  int sl_waits = 0, sl_lat = 0, sl_stat_i = 0, sl_res_i = 0;
  logic sl_resp = 1'b0, stray_ack = 1'b0, sl_we;
  logic [31:0] sl_adr, sl_dat, sl_r;
  initial begin
    wbm_ack_i = 0; wbm_err_i = 0; wbm_rty_i = 0; wbm_dat_i = 0;
    forever begin
      @(negedge clk);
      wbm_ack_i = 0; wbm_err_i = 0; wbm_rty_i = 0;
      if (stray_ack) begin
        wbm_ack_i = 1; stray_ack = 0;
      end else if (sl_resp) begin
        sl_resp = 0;
        if (wbm_cyc_o) stable_bad++;
      end else if (!wbm_cyc_o) begin
        sl_waits = 0;
      end else begin
        if (sl_waits == 0) begin
          sl_adr = wbm_adr_o; sl_we = wbm_we_o; sl_dat = wbm_dat_o;
          sl_lat = $urandom_range(0, lat_max);
        end else if (wbm_adr_o !== sl_adr || wbm_we_o !== sl_we || wbm_dat_o !== sl_dat)
          stable_bad++;
        if (wbm_stb_o !== 1'b1) stable_bad++;
        if (sl_waits >= sl_lat) begin
          sl_r = $urandom;
          if (sl_adr == A_STAT) begin
            wbm_dat_i = (sl_r & ~32'h1) | ((sl_stat_i >= n_zero) ? 32'h1 : 32'h0);
            sl_stat_i++;
          end else if (sl_adr == A_DOUT) begin
            wbm_dat_i = (sl_res_i < NO) ? results[sl_res_i] : sl_r;
            sl_res_i++;
          end else wbm_dat_i = sl_r;
          if (log_q.size() == err_idx) begin
            case (err_mode)
              0:       wbm_err_i = 1;
              1:       wbm_rty_i = 1;
              default: begin wbm_ack_i = 1; wbm_err_i = 1; end
            endcase
          end else wbm_ack_i = 1;
          log_q.push_back('{we: sl_we, adr: sl_adr, dat: sl_dat});
          sl_waits = 0; sl_resp = 1;
        end else sl_waits++;
      end
    end
  end

  // Input stream source with random bubbles.
  int fd_i = 0;
  logic fd_hs = 0, feed_en = 0;
  initial begin
    in_valid = 0; in_data = 0;
    forever begin
      @(negedge clk);
      if (fd_hs) fd_i++;
      if (feed_en && fd_i < NI && $urandom_range(0, 3) != 0) begin
        in_valid = 1; in_data = in_vals[fd_i];
      end else begin
        in_valid = 0; in_data = $urandom;
      end
      fd_hs = in_valid && in_ready;
    end
  end

  // Result sink: per-word stall, checks data hold and bus silence while stalled.
  int sk_w = 0, sk_stall = 0;
  logic sk_seen = 0;
  logic [31:0] sk_hold;
  initial begin
    out_ready = 0;
    forever begin
      @(negedge clk);
      out_ready = 0;
      if (out_valid) begin
        if (!sk_seen) begin
          sk_seen = 1; sk_hold = out_data;
          sk_stall = (sk_w < NO) ? stall_n[sk_w] : 0;
        end
        if (out_data !== sk_hold || wbm_cyc_o) bp_bad++;
        if (sk_stall > 0) sk_stall--;
        else begin
          out_ready = 1; out_q.push_back(out_data); sk_seen = 0; sk_w++;
        end
      end else if ($urandom_range(0, 1) == 1) out_ready = 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic cfg_job(input int nz, input int eidx, input int emode, input int lm);
    n_zero = nz; err_idx = eidx; err_mode = emode; lat_max = lm;
    for (int i = 0; i < NI; i++) in_vals[i] = $urandom;
    for (int i = 0; i < NO; i++) begin results[i] = $urandom; stall_n[i] = $urandom_range(0, 2); end
  endtask

  task automatic prep();
    log_q.delete(); out_q.delete();
    sl_stat_i = 0; sl_res_i = 0; sk_w = 0; sk_seen = 0;
    bp_bad = 0; stable_bad = 0; fd_i = 0; fd_hs = 0; feed_en = 1;
  endtask

  // Expected behaviour straight from the job description.
  int exp_err_last = 0;
  task automatic check_job(input string tag, input logic [1:0] err_seen);
    tx_t exp_q [$];
    int nout, eerr, npoll, n;
    bit tmo;
    for (int i = 0; i < NI; i++) exp_q.push_back('{we: 1'b1, adr: A_DIN, dat: in_vals[i]});
    exp_q.push_back('{we: 1'b1, adr: A_CTRL, dat: 32'h1});
    tmo = (n_zero >= PL);
    npoll = tmo ? PL : n_zero + 1;
    for (int i = 0; i < npoll; i++) exp_q.push_back('{we: 1'b0, adr: A_STAT, dat: 32'h0});
    if (!tmo) for (int i = 0; i < NO; i++) exp_q.push_back('{we: 1'b0, adr: A_DOUT, dat: 32'h0});
    eerr = tmo ? 2 : 0;
    nout = tmo ? 0 : NO;
    if (err_idx >= 0 && err_idx < exp_q.size()) begin
      nout = 0;
      for (int i = 0; i < err_idx; i++) if (exp_q[i].adr == A_DOUT) nout++;
      while (exp_q.size() > err_idx + 1) void'(exp_q.pop_back());
      eerr = 1;
    end
    exp_err_last = eerr;
    chk({tag, " job_err"}, err_seen, eerr);
    chk({tag, " tx count"}, log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s tx%0d we", tag, i), log_q[i].we, exp_q[i].we);
      chk($sformatf("%s tx%0d adr", tag, i), log_q[i].adr, exp_q[i].adr);
      if (exp_q[i].we) chk($sformatf("%s tx%0d dat", tag, i), log_q[i].dat, exp_q[i].dat);
    end
    chk({tag, " out count"}, out_q.size(), nout);
    n = (out_q.size() < nout) ? out_q.size() : nout;
    for (int i = 0; i < n; i++) chk($sformatf("%s out%0d", tag, i), out_q[i], results[i]);
    chk({tag, " backpressure hold"}, bp_bad, 0);
    chk({tag, " bus protocol"}, stable_bad, 0);
  endtask

  task automatic run_job(input string tag, input bit extra_start, input bit settle);
    int t, extra;
    logic got;
    logic [1:0] err_seen;
    prep();
    job_start = 1; @(negedge clk); job_start = 0;
    if (extra_start) begin
      repeat (3) @(negedge clk);
      chk({tag, " busy in LOAD"}, job_busy, 1);
      job_start = 1; @(negedge clk); job_start = 0;
    end
    t = 0;
    while (!job_done && t < 4000) begin @(negedge clk); t++; end
    got = job_done; err_seen = job_err;
    chk({tag, " done seen"}, got, 1);
    feed_en = 0;
    @(negedge clk);
    chk({tag, " done width"}, job_done, 0);
    check_job(tag, err_seen);
    if (settle) begin
      extra = 0;
      repeat (4) begin @(negedge clk); if (job_done) extra++; end
      chk({tag, " extra done"}, extra, 0);
      chk({tag, " job_err hold"}, job_err, exp_err_last);
      chk({tag, " idle busy"}, job_busy, 0);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " cyc"}, wbm_cyc_o, 0);
    chk({tag, " stb"}, wbm_stb_o, 0);
    chk({tag, " we"}, wbm_we_o, 0);
    chk({tag, " in_ready"}, in_ready, 0);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " busy"}, job_busy, 0);
    chk({tag, " done"}, job_done, 0);
    chk({tag, " err"}, job_err, 0);
    chk({tag, " adr"}, wbm_adr_o, 0);
    chk({tag, " dat"}, wbm_dat_o, 0);
    chk({tag, " out_data"}, out_data, 0);
  endtask

  initial begin
    int t;
    rst_sys = 1; job_start = 0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    chk("sel", wbm_sel_o, 4'hF);
    chk("cti", wbm_cti_o, 3'b000);
    chk("bte", wbm_bte_o, 2'b00);
    rst_sys = 0;
    repeat (2) @(negedge clk);

    // nominal: status 0,0,1, one-cycle acks
    cfg_job(2, -1, 0, 0);
    for (int i = 0; i < NI; i++) in_vals[i] = i + 1;
    results[0] = 32'hA; results[1] = 32'hB; results[2] = 32'hC; results[3] = 32'hD;
    for (int i = 0; i < NO; i++) stall_n[i] = 0;
    run_job("nominal", 0, 1);

    // backpressure on the second result
    cfg_job(2, -1, 0, 1);
    stall_n[0] = 0; stall_n[1] = 5; stall_n[2] = 0; stall_n[3] = 0;
    run_job("backpressure", 0, 1);

    // err on third LOAD write
    cfg_job(2, 2, 0, 1);
    run_job("load err", 0, 1);

    // ack+err together on the KICK write
    cfg_job(1, 4, 2, 0);
    run_job("kick ack+err", 0, 1);

    // retry on second status read
    cfg_job(3, 6, 1, 2);
    run_job("poll rty", 0, 1);

    // poll timeout
    cfg_job(100, -1, 0, 1);
    run_job("timeout", 0, 1);

    // job_start during LOAD is ignored
    cfg_job(1, -1, 0, 1);
    run_job("start in load", 1, 1);

    // back-to-back: second start in the cycle after done
    cfg_job(0, -1, 0, 0);
    run_job("b2b first", 0, 0);
    cfg_job(2, -1, 0, 0);
    run_job("b2b second", 0, 1);

    // reset while a status read is open
    cfg_job(100, -1, 0, 2);
    prep();
    job_start = 1; @(negedge clk); job_start = 0;
    t = 0;
    while (!(wbm_cyc_o && wbm_adr_o == A_STAT) && t < 500) begin @(negedge clk); t++; end
    chk("poll cycle open", wbm_cyc_o && wbm_adr_o == A_STAT, 1);
    rst_sys = 1;
    @(posedge clk); #1;
    chk_reset("mid-poll reset");
    @(negedge clk);
    rst_sys = 0; feed_en = 0; stray_ack = 1;
    repeat (3) @(negedge clk);
    chk("stray ack busy", job_busy, 0);
    chk("stray ack cyc", wbm_cyc_o, 0);
    cfg_job(2, -1, 0, 0);
    run_job("post-reset", 0, 1);

    // random jobs
    for (int k = 0; k < 8; k++) begin
      cfg_job($urandom_range(0, 9),
              ($urandom_range(0, 2) == 0) ? $urandom_range(0, 16) : -1,
              $urandom_range(0, 2), $urandom_range(0, 2));
      run_job($sformatf("rand%0d", k), 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
